fitness_eval_ctrl: RTL and testbench

//  Sequencer for the fitness-evaluation pipeline in the EC core.
//  - On start, optionally loads the self-energy vector and the interaction matrix into the evaluator.
//  - Streams POP_SIZE individuals from population memory into the evaluator, one per cycle.
//  - Collects results and writes each total energy to fitness memory at the individual's index.
//  - Signals done once every result has returned.

---
 rtl/ec_pkg.sv | 25 ++
 rtl/mem_rd_stage.sv | 38 +++
 rtl/fitness_eval_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fitness_eval_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ec_pkg.sv
// Shared constants and FSM encoding for the EC-core fitness evaluation path.
package ec_pkg;

   localparam int NUM_PARTICLE_TYPE = 3;
   localparam int DATA_WIDTH        = 4;
   localparam int INDIVIDUAL_LENGTH = 22;
   localparam int SELF_FIT_LENGTH   = 10;
   localparam int POP_SIZE          = 50;
   localparam int IDX_WIDTH         = 8;
   localparam int CFG_AW            = 4;
   localparam int EVAL_LATENCY      = 4;

   // Self energies first, then the interaction matrix row-major.
   localparam int CFG_WORDS = NUM_PARTICLE_TYPE + NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LOAD_WAIT,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_e;

endpackage

// File: rtl/mem_rd_stage.sv
// Delays a memory read request (strobe + address) by one cycle so it lines up
// with the synchronous read data coming back from the memory.
module mem_rd_stage #(
   parameter int AW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic [AW-1:0] addr_i,
   output logic          valid_o,
   output logic [AW-1:0] addr_o
);

   logic          valid_q, valid_d;
   logic [AW-1:0] addr_q,  addr_d;

   // Address is zeroed when idle so the downstream index bus stays quiet.
   always_comb begin
      valid_d = en_i;
      addr_d  = en_i ? addr_i : '0;
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   assign valid_o = valid_q;
   assign addr_o  = addr_q;

endmodule

// File: rtl/fitness_eval_ctrl.sv
// Fitness-evaluation sequencer: optional energy-table load, back-to-back
// population issue, result writeback to fitness memory and pass completion.
module fitness_eval_ctrl
   import ec_pkg::*;
(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic                         load_cfg_i,
   input  logic                         abort_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic                         cfg_rd_en_o,
   output logic [CFG_AW-1:0]            cfg_rd_addr_o,
   input  logic [DATA_WIDTH-1:0]        cfg_rd_data_i,
   output logic                         pop_rd_en_o,
   output logic [IDX_WIDTH-1:0]         pop_rd_addr_o,
   input  logic [INDIVIDUAL_LENGTH-1:0] pop_rd_data_i,
   output logic [DATA_WIDTH-1:0]        eval_energy_o,
   output logic                         eval_wr_se_o,
   output logic                         eval_wr_ie_o,
   output logic                         eval_in_valid_o,
   output logic [INDIVIDUAL_LENGTH-1:0] eval_ind_vec_o,
   output logic [IDX_WIDTH-1:0]         eval_ind_idx_o,
   input  logic                         eval_out_valid_i,
   input  logic [SELF_FIT_LENGTH-1:0]   eval_energy_i,
   input  logic [IDX_WIDTH-1:0]         eval_idx_i,
   output logic                         fit_wr_en_o,
   output logic [IDX_WIDTH-1:0]         fit_wr_addr_o,
   output logic [SELF_FIT_LENGTH-1:0]   fit_wr_data_o
);

   localparam logic [CFG_AW-1:0]    CFG_LAST   = CFG_AW'(CFG_WORDS - 1);
   localparam logic [CFG_AW-1:0]    SE_WORDS   = CFG_AW'(NUM_PARTICLE_TYPE);
   localparam logic [IDX_WIDTH-1:0] ISSUE_LAST = IDX_WIDTH'(POP_SIZE - 1);
   localparam logic [IDX_WIDTH-1:0] POP_COUNT  = IDX_WIDTH'(POP_SIZE);

   state_e                       state_q,       state_d;
   logic [CFG_AW-1:0]            cfg_cnt_q,     cfg_cnt_d;
   logic [IDX_WIDTH-1:0]         issue_cnt_q,   issue_cnt_d;
   logic [IDX_WIDTH-1:0]         result_cnt_q,  result_cnt_d;
   logic                         err_q,         err_d;
   logic                         fit_wr_en_q,   fit_wr_en_d;
   logic [IDX_WIDTH-1:0]         fit_wr_addr_q, fit_wr_addr_d;
   logic [SELF_FIT_LENGTH-1:0]   fit_wr_data_q, fit_wr_data_d;

   logic                         cfg_rd_en, pop_rd_en;
   logic                         cfg_dly_valid, pop_dly_valid;
   logic [CFG_AW-1:0]            cfg_dly_addr;
   logic [IDX_WIDTH-1:0]         pop_dly_addr;
   logic                         start_ok, result_ok;

   // Abort drops the read strobes in the same cycle, before the state changes.
   assign cfg_rd_en = (state_q == S_LOAD)  && !abort_i;
   assign pop_rd_en = (state_q == S_ISSUE) && !abort_i;
   assign start_ok  = (state_q == S_IDLE) && start_i && !abort_i;
   assign result_ok = eval_out_valid_i && !abort_i &&
                      ((state_q == S_ISSUE) || (state_q == S_DRAIN));

   mem_rd_stage #(.AW(CFG_AW)) u_cfg_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (cfg_rd_en),
      .addr_i  (cfg_cnt_q),
      .valid_o (cfg_dly_valid),
      .addr_o  (cfg_dly_addr)
   );

   mem_rd_stage #(.AW(IDX_WIDTH)) u_pop_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (pop_rd_en),
      .addr_i  (issue_cnt_q),
      .valid_o (pop_dly_valid),
      .addr_o  (pop_dly_addr)
   );

   always_comb begin
      // NOTE: every _d takes a default first so no branch of the case infers a latch.
      state_d       = state_q;
      cfg_cnt_d     = cfg_cnt_q;
      issue_cnt_d   = issue_cnt_q;
      result_cnt_d  = result_cnt_q;
      err_d         = err_q;
      fit_wr_en_d   = 1'b0;
      fit_wr_addr_d = fit_wr_addr_q;
      fit_wr_data_d = fit_wr_data_q;

      // Out-of-order results still get written; they only raise the sticky error.
      if (result_ok) begin
         fit_wr_en_d   = 1'b1;
         fit_wr_addr_d = eval_idx_i;
         fit_wr_data_d = eval_energy_i;
         result_cnt_d  = result_cnt_q + 1'b1;
         if (eval_idx_i != result_cnt_q) err_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               err_d        = 1'b0;
               cfg_cnt_d    = '0;
               issue_cnt_d  = '0;
               result_cnt_d = '0;
               state_d      = load_cfg_i ? S_LOAD : S_ISSUE;
            end
         end
         S_LOAD: begin
            cfg_cnt_d = cfg_cnt_q + 1'b1;
            if (cfg_cnt_q == CFG_LAST) begin
               cfg_cnt_d = '0;
               state_d   = S_LOAD_WAIT;
            end
         end
         S_LOAD_WAIT: state_d = S_ISSUE;
         S_ISSUE: begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            if (issue_cnt_q == ISSUE_LAST) begin
               issue_cnt_d = '0;
               state_d     = S_DRAIN;
            end
         end
         S_DRAIN: if (result_cnt_q == POP_COUNT) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort_i && (state_q != S_IDLE)) begin
         state_d      = S_IDLE;
         cfg_cnt_d    = '0;
         issue_cnt_d  = '0;
         result_cnt_d = '0;
      end
   end

   // NOTE: only control state is reset; the config, population and fitness
   // memories sit outside this block and keep their contents across rst_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         cfg_cnt_q     <= '0;
         issue_cnt_q   <= '0;
         result_cnt_q  <= '0;
         err_q         <= 1'b0;
         fit_wr_en_q   <= 1'b0;
         fit_wr_addr_q <= '0;
         fit_wr_data_q <= '0;
      end else begin
         state_q       <= state_d;
         cfg_cnt_q     <= cfg_cnt_d;
         issue_cnt_q   <= issue_cnt_d;
         result_cnt_q  <= result_cnt_d;
         err_q         <= err_d;
         fit_wr_en_q   <= fit_wr_en_d;
         fit_wr_addr_q <= fit_wr_addr_d;
         fit_wr_data_q <= fit_wr_data_d;
      end
   end

   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign err_o         = err_q;

   assign cfg_rd_en_o   = cfg_rd_en;
   assign cfg_rd_addr_o = cfg_cnt_q;
   assign pop_rd_en_o   = pop_rd_en;
   assign pop_rd_addr_o = issue_cnt_q;

   // Word class follows the address the data was read from, one cycle back.
   assign eval_energy_o   = cfg_dly_valid ? cfg_rd_data_i : '0;
   assign eval_wr_se_o    = cfg_dly_valid && (cfg_dly_addr < SE_WORDS);
   assign eval_wr_ie_o    = cfg_dly_valid && !(cfg_dly_addr < SE_WORDS);

   assign eval_in_valid_o = pop_dly_valid;
   assign eval_ind_idx_o  = pop_dly_addr;
   assign eval_ind_vec_o  = pop_dly_valid ? pop_rd_data_i : '0;

   assign fit_wr_en_o     = fit_wr_en_q;
   assign fit_wr_addr_o   = fit_wr_addr_q;
   assign fit_wr_data_o   = fit_wr_data_q;

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Bench for fitness_eval_ctrl: memory and evaluator models, a pass scoreboard
// driven from a scenario table, plus reset and randomized passes.
module tb_fitness_eval_ctrl;
   import ec_pkg::*;

   logic                         clk = 1'b0;
   logic                         rst_i = 1'b1;
   logic                         start_i = 1'b0, load_cfg_i = 1'b0, abort_i = 1'b0;
   logic                         busy_o, done_o, err_o;
   logic                         cfg_rd_en_o;
   logic [CFG_AW-1:0]            cfg_rd_addr_o;
   logic [DATA_WIDTH-1:0]        cfg_rd_data_i = '0;
   logic                         pop_rd_en_o;
   logic [IDX_WIDTH-1:0]         pop_rd_addr_o;
   logic [INDIVIDUAL_LENGTH-1:0] pop_rd_data_i = '0;
   logic [DATA_WIDTH-1:0]        eval_energy_o;
   logic                         eval_wr_se_o, eval_wr_ie_o, eval_in_valid_o;
   logic [INDIVIDUAL_LENGTH-1:0] eval_ind_vec_o;
   logic [IDX_WIDTH-1:0]         eval_ind_idx_o;
   logic                         eval_out_valid_i;
   logic [SELF_FIT_LENGTH-1:0]   eval_energy_i;
   logic [IDX_WIDTH-1:0]         eval_idx_i;
   logic                         fit_wr_en_o;
   logic [IDX_WIDTH-1:0]         fit_wr_addr_o;
   logic [SELF_FIT_LENGTH-1:0]   fit_wr_data_o;

   fitness_eval_ctrl dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .load_cfg_i(load_cfg_i),
      .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .cfg_rd_en_o(cfg_rd_en_o), .cfg_rd_addr_o(cfg_rd_addr_o), .cfg_rd_data_i(cfg_rd_data_i),
      .pop_rd_en_o(pop_rd_en_o), .pop_rd_addr_o(pop_rd_addr_o), .pop_rd_data_i(pop_rd_data_i),
      .eval_energy_o(eval_energy_o), .eval_wr_se_o(eval_wr_se_o), .eval_wr_ie_o(eval_wr_ie_o),
      .eval_in_valid_o(eval_in_valid_o), .eval_ind_vec_o(eval_ind_vec_o),
      .eval_ind_idx_o(eval_ind_idx_o), .eval_out_valid_i(eval_out_valid_i),
      .eval_energy_i(eval_energy_i), .eval_idx_i(eval_idx_i),
      .fit_wr_en_o(fit_wr_en_o), .fit_wr_addr_o(fit_wr_addr_o), .fit_wr_data_o(fit_wr_data_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory and evaluator models ----------------
   logic [DATA_WIDTH-1:0]        cfg_mem    [16];
   logic [INDIVIDUAL_LENGTH-1:0] pop_mem    [256];
   logic [SELF_FIT_LENGTH-1:0]   energy_tab [256];
   logic [SELF_FIT_LENGTH-1:0]   fit_mem    [256];
   bit                           bad6 = 1'b0;

   always @(posedge clk) begin
      if (cfg_rd_en_o) cfg_rd_data_i <= cfg_mem[cfg_rd_addr_o];
      if (pop_rd_en_o) pop_rd_data_i <= pop_mem[pop_rd_addr_o];
   end

   logic                       v_pipe [EVAL_LATENCY];
   logic [IDX_WIDTH-1:0]       i_pipe [EVAL_LATENCY];
   logic [SELF_FIT_LENGTH-1:0] e_pipe [EVAL_LATENCY];

   always @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < EVAL_LATENCY; k++) begin
            v_pipe[k] <= 1'b0; i_pipe[k] <= '0; e_pipe[k] <= '0;
         end
      end else begin
         v_pipe[0] <= eval_in_valid_o;
         i_pipe[0] <= (bad6 && eval_ind_idx_o == 8'd6) ? 8'd7 : eval_ind_idx_o;
         e_pipe[0] <= energy_tab[eval_ind_idx_o];
         for (int k = 1; k < EVAL_LATENCY; k++) begin
            v_pipe[k] <= v_pipe[k-1]; i_pipe[k] <= i_pipe[k-1]; e_pipe[k] <= e_pipe[k-1];
         end
      end
   end

   assign eval_out_valid_i = v_pipe[EVAL_LATENCY-1];
   assign eval_idx_i       = i_pipe[EVAL_LATENCY-1];
   assign eval_energy_i    = e_pipe[EVAL_LATENCY-1];

   // ---------------- observation (negedge, away from the active edge) ----------------
   int wr_cnt, first_fit, abort_cyc, late_wr, both_cnt, done_cnt, in_cnt, in_bad;
   logic [DATA_WIDTH-1:0] se_q[$], ie_q[$];

   always @(negedge clk) begin
      if (!rst_i) begin
         if (fit_wr_en_o) begin
            fit_mem[fit_wr_addr_o] = fit_wr_data_o;
            wr_cnt++;
            if (first_fit < 0) first_fit = cyc;
            if (abort_cyc >= 0 && cyc > abort_cyc) late_wr++;
         end
         if (eval_wr_se_o) se_q.push_back(eval_energy_o);
         if (eval_wr_ie_o) ie_q.push_back(eval_energy_o);
         if (eval_wr_se_o && eval_wr_ie_o) both_cnt++;
         if (done_o) done_cnt++;
         if (eval_in_valid_o) begin
            if (int'(eval_ind_idx_o) != in_cnt || eval_ind_vec_o != pop_mem[eval_ind_idx_o]) in_bad++;
            in_cnt++;
         end
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0, n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic any_output();
      return |{busy_o, done_o, err_o, cfg_rd_en_o, cfg_rd_addr_o, pop_rd_en_o, pop_rd_addr_o,
               eval_energy_o, eval_wr_se_o, eval_wr_ie_o, eval_in_valid_o, eval_ind_vec_o,
               eval_ind_idx_o, fit_wr_en_o, fit_wr_addr_o, fit_wr_data_o};
   endfunction

   // Start-to-first-write latency straight from the pipeline description.
   function automatic int exp_lat(input bit load);
      return 1 + (load ? CFG_WORDS + 1 : 0) + 1 + EVAL_LATENCY + 1;
   endfunction

   typedef struct {
      bit load;        bit rnd;          bit bad6;      bit busy_start;
      bit start_abort; int abort_at;     int exp_writes; int exp_done;
      bit exp_err;     int exp_issued;
   } vec_t;

   task automatic run_pass(input vec_t v, input int id);
      int start_cyc, done_cyc, mism;
      bit idle_checked;
      for (int i = 0; i < 16; i++) cfg_mem[i] = v.rnd ? DATA_WIDTH'($urandom) : DATA_WIDTH'(i + 1);
      for (int i = 0; i < 256; i++) begin
         pop_mem[i]    = INDIVIDUAL_LENGTH'($urandom);
         energy_tab[i] = v.rnd ? SELF_FIT_LENGTH'($urandom) : SELF_FIT_LENGTH'(i + 100);
         fit_mem[i]    = '0;
      end
      bad6 = v.bad6;
      wr_cnt = 0; first_fit = -1; abort_cyc = -1; late_wr = 0; both_cnt = 0;
      done_cnt = 0; in_cnt = 0; in_bad = 0; se_q.delete(); ie_q.delete();
      idle_checked = 1'b0; done_cyc = -1;

      @(posedge clk); #1;
      if (v.start_abort) begin
         start_i = 1'b1; load_cfg_i = 1'b1; abort_i = 1'b1;
         @(posedge clk); #1;
         start_i = 1'b0; load_cfg_i = 1'b0; abort_i = 1'b0;
         check($sformatf("p%0d start_with_abort_ignored", id), busy_o, 0);
      end

      start_i = 1'b1; load_cfg_i = v.load; start_cyc = cyc;
      @(posedge clk); #1;
      start_i = 1'b0; load_cfg_i = 1'b0;
      check($sformatf("p%0d busy_after_start", id), busy_o, 1);
      check($sformatf("p%0d err_cleared_by_start", id), err_o, 0);

      for (int t = 0; t < 400; t++) begin
         if (!busy_o) break;
         if (done_o) done_cyc = cyc;
         start_i    = v.busy_start && (t == 10);
         load_cfg_i = start_i;
         if (v.abort_at >= 0 && abort_cyc < 0 && pop_rd_en_o && int'(pop_rd_addr_o) == v.abort_at) begin
            abort_i = 1'b1; abort_cyc = cyc;
            #1 check($sformatf("p%0d rd_en_low_on_abort", id), pop_rd_en_o, 0);
         end
         @(posedge clk); #1;
         abort_i = 1'b0;
         if (abort_cyc >= 0 && !idle_checked) begin
            idle_checked = 1'b1;
            check($sformatf("p%0d idle_after_abort", id), busy_o, 0);
         end
      end
      start_i = 1'b0; load_cfg_i = 1'b0;
      check($sformatf("p%0d pass_terminates", id), busy_o, 0);
      if (v.exp_done != 0)
         check($sformatf("p%0d busy_low_after_done", id), 64'(cyc - done_cyc), 1);

      repeat (12) @(posedge clk);
      #1;
      check($sformatf("p%0d fit_writes", id), wr_cnt, v.exp_writes);
      check($sformatf("p%0d done_pulses", id), done_cnt, v.exp_done);
      check($sformatf("p%0d err_sticky", id), err_o, v.exp_err);
      check($sformatf("p%0d first_write_latency", id), 64'(first_fit - start_cyc), exp_lat(v.load));
      check($sformatf("p%0d issued", id), in_cnt, v.exp_issued);
      check($sformatf("p%0d issue_order_and_data", id), in_bad, 0);
      check($sformatf("p%0d late_writes_after_abort", id), late_wr, 0);
      check($sformatf("p%0d se_strobes", id), se_q.size(), v.load ? NUM_PARTICLE_TYPE : 0);
      check($sformatf("p%0d ie_strobes", id), ie_q.size(), v.load ? CFG_WORDS - NUM_PARTICLE_TYPE : 0);
      check($sformatf("p%0d both_strobes", id), both_cnt, 0);
      if (v.load) begin
         mism = 0;
         for (int i = 0; i < se_q.size(); i++) if (se_q[i] != cfg_mem[i]) mism++;
         for (int i = 0; i < ie_q.size(); i++) if (ie_q[i] != cfg_mem[NUM_PARTICLE_TYPE + i]) mism++;
         check($sformatf("p%0d cfg_word_values", id), mism, 0);
      end
      if (!v.bad6 && v.abort_at < 0) begin
         mism = 0;
         for (int i = 0; i < POP_SIZE; i++) if (fit_mem[i] !== energy_tab[i]) mism++;
         check($sformatf("p%0d fitness_memory", id), mism, 0);
      end
   endtask

   vec_t vecs[7];

   initial begin
      //           load rnd bad6 bstart sabort abort_at writes done err issued
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 50, 1, 1'b0, 50};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 50, 1, 1'b0, 50};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 50, 1, 1'b1, 50};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20, 15, 0, 1'b0, 20};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1, 50, 1, 1'b0, 50};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, 50, 1, 1'b0, 50};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 50, 1, 1'b0, 50};

      for (int i = 0; i < 256; i++) begin
         pop_mem[i] = INDIVIDUAL_LENGTH'($urandom); energy_tab[i] = SELF_FIT_LENGTH'(i);
      end
      for (int i = 0; i < 16; i++) cfg_mem[i] = DATA_WIDTH'(i);

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs_zero", any_output(), 0);
      rst_i = 1'b0;

      // Reset in the middle of ISSUE.
      @(posedge clk); #1;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int t = 0; t < 100 && pop_rd_addr_o != 8'd10; t++) begin
         @(posedge clk); #1;
      end
      check("reached_issue_before_reset", pop_rd_addr_o, 10);
      rst_i = 1'b1;
      #1 check("async_reset_outputs_zero", any_output(), 0);
      @(posedge clk); #1;
      check("reset_held_outputs_zero", any_output(), 0);
      rst_i = 1'b0;

      foreach (vecs[i]) run_pass(vecs[i], i);

      for (int r = 0; r < 3; r++) begin
         vec_t v;
         v = '{1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, -1, 50, 1, 1'b0, 50};
         run_pass(v, 10 + r);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
